fc3_argmax_seq: RTL and testbench

- Sequential arg-max stage directly downstream of the fc3 double-buffered accumulator.
- Consumes one signed class score per valid beat from the accumulator's output bank, in class order 0..NCLS-1.
- Tracks the running maximum score and its index.
- Emits the winning class index and score once per frame as the final classification result.

---
 rtl/fc3_argmax_seq.sv | 118 +++++++++++
 tb/tb_fc3_argmax_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fc3_argmax_seq.sv
// fc3_argmax_seq: running arg-max over the NCLS class scores of one frame.
// Scores arrive one per valid beat in class order; the winner (lowest index
// on ties) is published with a one-cycle oValid pulse after the last beat.
module fc3_argmax_seq #(
  parameter int IWID = $clog2(110*32)+1+10,
  parameter int NCLS = 10,
  parameter int IDXW = $clog2(NCLS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   iStart,
  input  logic                   iValid,
  input  logic signed [IWID-1:0] iData,
  output logic                   oBusy,
  output logic                   oValid,
  output logic        [IDXW-1:0] oIdx,
  output logic signed [IWID-1:0] oMax,
  output logic                   oErr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic        [IDXW-1:0] cnt_q, cnt_d;
  logic signed [IWID-1:0] max_q, max_d;
  logic        [IDXW-1:0] idx_q, idx_d;
  logic signed [IWID-1:0] res_max_q, res_max_d;
  logic        [IDXW-1:0] res_idx_q, res_idx_d;
  logic                   err_q, err_d;

  logic        [IDXW-1:0] cnt_eff;
  logic                   in_frame;
  logic signed [IWID-1:0] win_max;
  logic        [IDXW-1:0] win_idx;

  // Next-state: frame open/abort, beat acceptance, running compare, result load.
  always_comb begin
    state_d   = (state_q == S_DONE) ? S_IDLE : state_q;
    cnt_d     = cnt_q;
    max_d     = max_q;
    idx_d     = idx_q;
    res_max_d = res_max_q;
    res_idx_d = res_idx_q;
    err_d     = err_q;
    cnt_eff   = cnt_q;
    in_frame  = (state_q == S_COLLECT);
    win_max   = max_q;
    win_idx   = idx_q;

    // iStart opens (or restarts) a frame; a beat in the same cycle is class 0.
    if (iStart) begin
      state_d  = S_COLLECT;
      cnt_d    = '0;
      cnt_eff  = '0;
      err_d    = 1'b0;
      in_frame = 1'b1;
    end

    if (iValid) begin
      if (in_frame) begin
        if (cnt_eff == '0) begin
          win_max = iData;
          win_idx = '0;
        end else if (iData > max_q) begin
          win_max = iData;
          win_idx = cnt_eff;
        end
        max_d = win_max;
        idx_d = win_idx;
        if (cnt_eff == IDXW'(NCLS-1)) begin
          state_d   = S_DONE;
          cnt_d     = '0;
          res_max_d = win_max;
          res_idx_d = win_idx;
        end else begin
          cnt_d = cnt_eff + 1'b1;
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      max_q     <= '0;
      idx_q     <= '0;
      res_max_q <= '0;
      res_idx_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      max_q     <= max_d;
      idx_q     <= idx_d;
      res_max_q <= res_max_d;
      res_idx_q <= res_idx_d;
      err_q     <= err_d;
    end
  end

  // Outputs decoded from registered state.
  always_comb begin
    oBusy  = (state_q == S_COLLECT);
    oValid = (state_q == S_DONE);
    oIdx   = res_idx_q;
    oMax   = res_max_q;
    oErr   = err_q;
  end

endmodule

// File: tb/tb_fc3_argmax_seq.sv
// Self-checking bench for fc3_argmax_seq: directed test-plan steps followed by
// random frames, all compared every cycle against a queue-based frame model.
module tb_fc3_argmax_seq;

  localparam int IWID = 23;
  localparam int NCLS = 10;
  localparam int IDXW = 4;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   iStart;
  logic                   iValid;
  logic signed [IWID-1:0] iData;
  logic                   oBusy;
  logic                   oValid;
  logic        [IDXW-1:0] oIdx;
  logic signed [IWID-1:0] oMax;
  logic                   oErr;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic signed [IWID-1:0] scores[$];
  bit                     m_in_frame;
  bit                     m_pulse;
  bit                     m_err;
  int                     m_idx;
  logic signed [IWID-1:0] m_max;

  fc3_argmax_seq #(.IWID(IWID), .NCLS(NCLS), .IDXW(IDXW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .iStart (iStart),
    .iValid (iValid),
    .iData  (iData),
    .oBusy  (oBusy),
    .oValid (oValid),
    .oIdx   (oIdx),
    .oMax   (oMax),
    .oErr   (oErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame-level model: collect scores; on the NCLS-th, pick the first maximum.
  task automatic model_edge(input logic r, input logic st, input logic v,
                            input logic signed [IWID-1:0] d);
    m_pulse = 1'b0;
    if (!r) begin
      m_in_frame = 1'b0;
      scores.delete();
      m_err = 1'b0;
      m_idx = 0;
      m_max = '0;
    end else begin
      if (st) begin
        m_in_frame = 1'b1;
        scores.delete();
        m_err = 1'b0;
      end
      if (v) begin
        if (m_in_frame) begin
          scores.push_back(d);
          if (scores.size() == NCLS) begin
            m_idx = 0;
            m_max = scores[0];
            for (int i = 1; i < NCLS; i++)
              if (scores[i] > m_max) begin
                m_max = scores[i];
                m_idx = i;
              end
            m_pulse = 1'b1;
            m_in_frame = 1'b0;
            scores.delete();
          end
        end else begin
          m_err = 1'b1;
        end
      end
    end
  endtask

  // Apply inputs for one clock, update the model, compare just after the edge.
  task automatic step(input logic st, input logic v, input logic signed [IWID-1:0] d);
    iStart = st;
    iValid = v;
    iData  = d;
    @(posedge clk);
    model_edge(rst_n, st, v, d);
    #1;
    chk("oValid", 32'(oValid), 32'(m_pulse));
    chk("oBusy",  32'(oBusy),  32'(m_in_frame));
    chk("oErr",   32'(oErr),   32'(m_err));
    chk("oIdx",   32'(oIdx),   32'(m_idx));
    chk("oMax",   32'(oMax),   32'(m_max));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
  endtask

  // Directed expectation written straight from the test plan.
  task automatic chk_res(input string tag, input int idx, input logic signed [IWID-1:0] mx);
    chk({tag, "_valid"}, 32'(oValid), 32'd1);
    chk({tag, "_idx"},   32'(oIdx),   32'(idx));
    chk({tag, "_max"},   32'(oMax),   32'(mx));
  endtask

  function automatic logic signed [IWID-1:0] rnd_score();
    logic signed [IWID-1:0] s;
    case ($urandom_range(0, 3))
      0:       s = IWID'($signed($urandom_range(0, 8)) - 4);
      1:       s = {1'b1, {(IWID-1){1'b0}}};
      2:       s = {1'b0, {(IWID-1){1'b1}}};
      default: s = IWID'($urandom);
    endcase
    return s;
  endfunction

  initial begin
    logic signed [IWID-1:0] basic[NCLS];
    logic signed [IWID-1:0] neg[NCLS];
    logic signed [IWID-1:0] most_neg;
    most_neg = {1'b1, {(IWID-1){1'b0}}};
    basic = '{23'sd5, -23'sd3, 23'sd100, 23'sd7, 23'sd99, 23'sd0, -23'sd50, 23'sd100, 23'sd2, 23'sd1};
    neg   = '{-23'sd10, -23'sd4, -23'sd4, most_neg, -23'sd9, -23'sd8, -23'sd7, -23'sd6, -23'sd5, -23'sd20};

    rst_n = 1'b0; iStart = 1'b0; iValid = 1'b0; iData = '0;
    m_in_frame = 1'b0; m_pulse = 1'b0; m_err = 1'b0; m_idx = 0; m_max = '0;
    step(1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 23'sd77);   // reset wins over start/valid
    chk("rst_busy", 32'(oBusy), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Basic frame, ties keep lower index
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < NCLS; i++) step(1'b0, 1'b1, basic[i]);
    chk_res("basic", 2, 23'sd100);
    chk("basic_err", 32'(oErr), 32'd0);
    idle(2);

    // All negative with 3-cycle gaps
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < NCLS; i++) begin
      step(1'b0, 1'b1, neg[i]);
      if (i != NCLS-1) begin
        idle(3);
        chk("neg_busy", 32'(oBusy), 32'd1);
      end
    end
    chk_res("neg", 1, -23'sd4);
    idle(1);

    // Last beat wins, then back-to-back frame started during DONE
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < NCLS; i++) step(1'b0, 1'b1, (i == NCLS-1) ? 23'sd50 : 23'sd0);
    chk_res("lastwin", 9, 23'sd50);
    step(1'b1, 1'b1, 23'sd9);
    for (int i = 1; i < NCLS; i++) step(1'b0, 1'b1, 23'sd0);
    chk_res("b2b", 0, 23'sd9);
    idle(1);

    // Abort mid-frame, then full 1..10
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 23'sd1000);
    step(1'b1, 1'b0, '0);
    chk("abort_idx", 32'(oIdx), 32'd0);
    chk("abort_max", 32'(oMax), 32'd9);
    for (int i = 0; i < NCLS; i++) step(1'b0, 1'b1, IWID'(i + 1));
    chk_res("abort", 9, 23'sd10);
    idle(1);

    // Protocol error in IDLE, cleared by next start
    step(1'b0, 1'b1, 23'sd5);
    chk("perr_set", 32'(oErr), 32'd1);
    chk("perr_busy", 32'(oBusy), 32'd0);
    step(1'b1, 1'b0, '0);
    chk("perr_clr", 32'(oErr), 32'd0);

    // Reset mid-frame after 6 beats
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 23'sd3);
    rst_n = 1'b0;
    step(1'b0, 1'b0, '0);
    rst_n = 1'b1;
    chk("mrst_idx", 32'(oIdx), 32'd0);
    chk("mrst_max", 32'(oMax), 32'd0);
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < NCLS; i++) step(1'b0, 1'b1, (i == 4) ? 23'sd8 : -23'sd1);
    chk_res("mrst", 4, 23'sd8);

    // Random frames with gaps, occasional aborts, stray beats and start+valid
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 4) == 0) step(1'b0, 1'b1, rnd_score());
      if ($urandom_range(0, 1) == 0) step(1'b1, 1'b0, '0);
      else                          step(1'b1, 1'b1, rnd_score());
      for (int b = 0; b < 2 * NCLS; b++) begin
        if (!m_in_frame) break;
        if ($urandom_range(0, 3) == 0) step(1'b0, 1'b0, rnd_score());
        else if ($urandom_range(0, 40) == 0) step(1'b1, 1'b0, '0);
        else step(1'b0, 1'b1, rnd_score());
      end
      idle($urandom_range(0, 2));
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
